risc16_memctl: RTL
==================

# risc16_memctl

Memory controller and run sequencer for the `risc16ba` core. It owns the core's reset and shares the instruction and data memories between the core and a host port. The host uses that port to load programs and data while the core is held in reset, and reads or writes data memory in idle cycles while the core runs. The block sits between `risc16ba`, the two asynchronous-read memories and the host/debug interface.

## Interface
Parameters:
- FLUSH_CYCLES, 4: cycles `cpu_rst` stays high in BOOT so the pipeline fills with NOPs.
- STARVE_MAX, 64: number of consecutive ungranted host-request cycles that sets `h_starved`.
- WDT_LIMIT, 1000000: number of RUN cycles before the watchdog fires (only with `MEMCTL_WATCHDOG_EN`).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- h_req  in  1  host request; held stable until `h_gnt`.
- h_sel  in  1  target memory: 0 = imem, 1 = dmem.
- h_we  in  1  1 = write, 0 = read.
- h_be_hi / h_be_lo  in  1 each  byte enables for bits [15:8] and [7:0].
- h_addr  in  16  byte address.
- h_wdata  in  16  write data.
- h_gnt  out  1  request accepted this cycle.
- h_rvalid  out  1  read data valid.
- h_rdata  out  16  read data.
- h_run / h_halt  in  1 each  start / stop pulses.
- running  out  1  state == RUN.
- h_starved  out  1  sticky starvation flag; cleared by `h_run`.
- wdt_fired  out  1  sticky watchdog flag; cleared by `h_run`.
- cpu_rst  out  1  reset to the core.
- cpu_iaddr, cpu_ioe  in  16, 1  core fetch port.
- cpu_idin  out  16  fetched word to the core.
- cpu_daddr, cpu_ddout, cpu_doe, cpu_dwe0, cpu_dwe1  in  16, 16, 1, 1, 1  core data port.
- cpu_ddin  out  16  data read to the core.
- imem_addr, imem_din, imem_we0, imem_we1  out  16, 16, 1, 1  instruction memory.
- imem_dout  in  16  instruction memory read data.
- dmem_addr, dmem_din, dmem_we0, dmem_we1  out  16, 16, 1, 1  data memory.
- dmem_dout  in  16  data memory read data.

## Operation
- Memories are asynchronous-read (data valid in the same cycle as the address).
- Byte lanes: `we0` selects bits [15:8] and `we1` selects bits [7:0]. `h_be_hi` maps to `we0`, `h_be_lo` maps to `we1`.
- States:
  - LOAD (reset state): `cpu_rst`=1. The host owns both memories; any `h_req` is granted in the same cycle.
  - BOOT: `cpu_rst`=1; no host grants; a down-counter runs for FLUSH_CYCLES cycles.
  - RUN: `cpu_rst`=0.
- Transitions:
  - LOAD, `h_run` -> BOOT. The counter loads FLUSH_CYCLES and the sticky flags clear.
  - BOOT, counter reaches 0 -> RUN.
  - BOOT or RUN, `h_halt` -> LOAD.
  - `h_halt` and `h_run` asserted together: halt wins.
  - `h_run` in BOOT or RUN is ignored.
- RUN arbitration:
  - imem always belongs to the core; host imem requests wait until LOAD.
  - dmem: the core has absolute priority. The host is granted only when `cpu_doe`, `cpu_dwe0` and `cpu_dwe1` are all 0.
- Memory buses: the memory address and write strobes come from the grant owner. With no grant, the core drives them (`cpu_ddin` = `dmem_dout`, `cpu_idin` = `imem_dout`).
- Host write: the grant cycle drives `h_be_*` onto `we0`/`we1` for exactly that cycle.
- Host read: the grant cycle captures `*_dout` into `h_rdata`; `h_rvalid` pulses in the following cycle.
- Starvation: a counter increments on each cycle with `h_req`=1 and `h_gnt`=0, and clears on grant. Reaching STARVE_MAX sets `h_starved`. The counter saturates and does not wrap.
- A grant issued in the same cycle as `h_halt` completes normally.

## Timing
- Reset values: state LOAD, `cpu_rst`=1, `h_gnt`=0, `h_rvalid`=0, `h_rdata`=0, `running`=0, `h_starved`=0, `wdt_fired`=0, all memory `we`=0.
- `h_gnt` is combinational from `h_req`, the current state and the core's data strobes.
- Read latency: 1 cycle from grant to `h_rvalid`.
- Throughput: one host transaction per cycle.
- `h_run` in cycle t: `cpu_rst` falls at the end of cycle t+1+FLUSH_CYCLES; `running`=1 from the same cycle.
- `h_halt` in cycle t: `cpu_rst`=1 and `running`=0 from cycle t+1.
- `rst` in the middle of a transaction: the transaction is dropped, `h_rvalid` stays 0, and all counters clear.

## Configuration
- `MEMCTL_WATCHDOG_EN` defined: a RUN-cycle counter is built, sized `$clog2(WDT_LIMIT+1)` bits and cleared on entry to RUN. When it reaches WDT_LIMIT, the state moves to LOAD and `wdt_fired` sets.
- `MEMCTL_WATCHDOG_EN` undefined: no counter is built, `wdt_fired` is tied to 0, and RUN is left only via `h_halt` or `rst`.

## Structure
- `memctl_pkg` holds:
  - state enum `memctl_state_t` {ST_LOAD, ST_BOOT, ST_RUN};
  - `SEL_IMEM`/`SEL_DMEM` constants;
  - the byte-lane mapping helper.
- Sub-module `dmem_arb` (combinational grant plus the starvation counter) is instantiated once. The top level holds the FSM, the boot counter, the watchdog and the read-data register.

## Test plan
- Load: in LOAD, host writes imem[0x0000]=0x1234 with both enables, then reads it -> `h_gnt` in the same cycle; next cycle `h_rvalid`=1 and `h_rdata`=0x1234.
- Byte write: in LOAD, dmem[0x10]=0xAAAA, then host writes 0x0055 with only `h_be_lo` -> read returns 0xAA55.
- Boot: `h_run` at cycle 10 with FLUSH_CYCLES=4 -> `cpu_rst`=1 through cycle 15 and 0 from cycle 16; `running`=1 from cycle 16.
- Arbitration: in RUN, the core holds `cpu_doe`=1 for 70 cycles while `h_req`=1 -> no grant during that window; `h_starved` sets at 64; grant in the first cycle the strobes are 0.
- Halt priority: `h_run` and `h_halt` asserted together in BOOT -> next cycle LOAD with `cpu_rst`=1; a host imem read in RUN is granted only after the halt.
- Watchdog (macro on, WDT_LIMIT=100): stay in RUN -> LOAD and `wdt_fired`=1 after 100 RUN cycles. With the macro off -> still RUN at cycle 1000.

Source files
------------

// File: rtl/risc16_memctl_pkg.sv
// Shared types and helpers for the risc16 memory controller / run sequencer.
package memctl_pkg;

    // Run-sequencer states: host-owned LOAD, pipeline-flush BOOT, core RUN
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } memctl_state_t;

    // Host target memory select
    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    // Byte-lane mapping: result[1] is we0 (bits 15:8), result[0] is we1 (bits 7:0)
    function automatic logic [1:0] lane_we(input logic we, input logic be_hi, input logic be_lo);
        return {we & be_hi, we & be_lo};
    endfunction

endpackage

// File: rtl/risc16_memctl_dmem_arb.sv
// Host grant logic and host starvation tracking for risc16_memctl.
// The core always wins data memory in RUN; the host only gets idle cycles.
module dmem_arb
    import memctl_pkg::*;
#(
    parameter int STARVE_MAX = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  memctl_state_t state,
    input  logic          h_req,
    input  logic          h_sel,
    input  logic          cpu_doe,
    input  logic          cpu_dwe0,
    input  logic          cpu_dwe1,
    input  logic          flag_clr,
    output logic          h_gnt,
    output logic          h_starved
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

    logic          h_gnt_s;
    logic [SW-1:0] starve_cnt_r;
    logic [SW-1:0] starve_cnt_next_s;
    logic          h_starved_r;

    // Grant decision: everything in LOAD, idle dmem cycles in RUN, nothing in BOOT
    always_comb begin
        h_gnt_s = 1'b0;
        case (state)
            ST_LOAD: h_gnt_s = h_req;
            ST_RUN: begin
                if ((h_sel == SEL_DMEM) && !(cpu_doe | cpu_dwe0 | cpu_dwe1)) begin
                    h_gnt_s = h_req;
                end else begin
                    h_gnt_s = 1'b0;
                end
            end
            ST_BOOT: h_gnt_s = 1'b0;
            default: h_gnt_s = 1'b0;
        endcase
    end

    // Next starvation count: clear on grant, saturating count while refused
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        if (h_gnt_s) begin
            starve_cnt_next_s = '0;
        end else if (h_req && (starve_cnt_r != STARVE_MAX_C)) begin
            starve_cnt_next_s = starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // Starvation counter and sticky flag (flag cleared when a new run starts)
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
            h_starved_r  <= 1'b0;
        end else begin
            starve_cnt_r <= starve_cnt_next_s;
            if (flag_clr) begin
                h_starved_r <= 1'b0;
            end else if (starve_cnt_next_s == STARVE_MAX_C) begin
                h_starved_r <= 1'b1;
            end
        end
    end

    assign h_gnt     = h_gnt_s;
    assign h_starved = h_starved_r;

endmodule

// File: rtl/risc16_memctl.sv
// risc16_memctl: run sequencer and memory sharing between the risc16ba core
// and the host port. Optional watchdog enabled by defining MEMCTL_WATCHDOG_EN.
module risc16_memctl
    import memctl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int STARVE_MAX   = 64,
    parameter int WDT_LIMIT    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_req,
    input  logic        h_sel,
    input  logic        h_we,
    input  logic        h_be_hi,
    input  logic        h_be_lo,
    input  logic [15:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_gnt,
    output logic        h_rvalid,
    output logic [15:0] h_rdata,
    input  logic        h_run,
    input  logic        h_halt,
    output logic        running,
    output logic        h_starved,
    output logic        wdt_fired,
    output logic        cpu_rst,
    input  logic [15:0] cpu_iaddr,
    input  logic        cpu_ioe,
    output logic [15:0] cpu_idin,
    input  logic [15:0] cpu_daddr,
    input  logic [15:0] cpu_ddout,
    input  logic        cpu_doe,
    input  logic        cpu_dwe0,
    input  logic        cpu_dwe1,
    output logic [15:0] cpu_ddin,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_din,
    output logic        imem_we0,
    output logic        imem_we1,
    input  logic [15:0] imem_dout,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    output logic        dmem_we0,
    output logic        dmem_we1,
    input  logic [15:0] dmem_dout
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    memctl_state_t state_r;
    memctl_state_t state_next_s;
    logic [FW-1:0] boot_cnt_r;
    logic          flag_clr_s;
    logic          wdt_trip_s;
    logic          cpu_rst_r;
    logic          running_r;
    logic          h_rvalid_r;
    logic [15:0]   h_rdata_r;
    logic          h_gnt_s;
    logic          host_imem_s;
    logic          host_dmem_s;
    logic [1:0]    host_we_s;
    logic          unused_ok_s;

    // The core fetch enable carries no information here: imem is always the core's in RUN
    assign unused_ok_s = cpu_ioe;

    dmem_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_dmem_arb (
        .clk       (clk),
        .rst       (rst),
        .state     (state_r),
        .h_req     (h_req),
        .h_sel     (h_sel),
        .cpu_doe   (cpu_doe),
        .cpu_dwe0  (cpu_dwe0),
        .cpu_dwe1  (cpu_dwe1),
        .flag_clr  (flag_clr_s),
        .h_gnt     (h_gnt_s),
        .h_starved (h_starved)
    );

    // Sequencer next state; halt beats run, run only counts in LOAD
    always_comb begin
        state_next_s = state_r;
        flag_clr_s   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (h_halt) begin
                    state_next_s = ST_LOAD;
                end else if (h_run) begin
                    state_next_s = ST_BOOT;
                    flag_clr_s   = 1'b1;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_BOOT: begin
                if (h_halt) begin
                    state_next_s = ST_LOAD;
                end else if (boot_cnt_r == FW'(0)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (h_halt || wdt_trip_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State register plus registered core reset / running indications
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_LOAD;
            cpu_rst_r <= 1'b1;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cpu_rst_r <= (state_next_s != ST_RUN);
            running_r <= (state_next_s == ST_RUN);
        end
    end

    // Boot flush counter: loaded on run, counts down while in BOOT
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_cnt_r <= '0;
        end else if (flag_clr_s) begin
            boot_cnt_r <= FW'(FLUSH_CYCLES);
        end else if ((state_r == ST_BOOT) && (boot_cnt_r != FW'(0))) begin
            boot_cnt_r <= boot_cnt_r - FW'(1);
        end
    end

`ifdef MEMCTL_WATCHDOG_EN
    localparam int WW = $clog2(WDT_LIMIT + 1);
    logic [WW-1:0] wdt_cnt_r;
    logic          wdt_fired_r;

    // Trip on the last of WDT_LIMIT consecutive RUN cycles
    assign wdt_trip_s = (state_r == ST_RUN) && (wdt_cnt_r == WW'(WDT_LIMIT - 1));

    // RUN-cycle counter; held at zero outside RUN so every RUN entry starts fresh
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_r <= '0;
        end else if (state_r != ST_RUN) begin
            wdt_cnt_r <= '0;
        end else begin
            wdt_cnt_r <= wdt_cnt_r + WW'(1);
        end
    end

    // Sticky watchdog flag, cleared when a new run starts
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_fired_r <= 1'b0;
        end else if (flag_clr_s) begin
            wdt_fired_r <= 1'b0;
        end else if (wdt_trip_s) begin
            wdt_fired_r <= 1'b1;
        end
    end

    assign wdt_fired = wdt_fired_r;
`else
    localparam int unused_wdt_limit_c = WDT_LIMIT;
    assign wdt_trip_s = 1'b0;
    assign wdt_fired  = 1'b0;
`endif

    assign host_imem_s = h_gnt_s && (h_sel == SEL_IMEM);
    assign host_dmem_s = h_gnt_s && (h_sel == SEL_DMEM);
    assign host_we_s   = lane_we(h_we, h_be_hi, h_be_lo);

    // Memory bus steering: grant owner drives, otherwise the core; core data
    // writes are suppressed while it is held in reset
    always_comb begin
        imem_addr = cpu_iaddr;
        imem_din  = 16'h0000;
        imem_we0  = 1'b0;
        imem_we1  = 1'b0;
        dmem_addr = cpu_daddr;
        dmem_din  = cpu_ddout;
        dmem_we0  = cpu_dwe0 & ~cpu_rst_r;
        dmem_we1  = cpu_dwe1 & ~cpu_rst_r;
        if (host_imem_s) begin
            imem_addr = h_addr;
            imem_din  = h_wdata;
            imem_we0  = host_we_s[1];
            imem_we1  = host_we_s[0];
        end else begin
            imem_addr = cpu_iaddr;
        end
        if (host_dmem_s) begin
            dmem_addr = h_addr;
            dmem_din  = h_wdata;
            dmem_we0  = host_we_s[1];
            dmem_we1  = host_we_s[0];
        end else begin
            dmem_addr = cpu_daddr;
        end
    end

    // Host read capture on the grant cycle, valid pulse one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            h_rvalid_r <= 1'b0;
            h_rdata_r  <= 16'h0000;
        end else if (h_gnt_s && !h_we) begin
            h_rvalid_r <= 1'b1;
            h_rdata_r  <= (h_sel == SEL_DMEM) ? dmem_dout : imem_dout;
        end else begin
            h_rvalid_r <= 1'b0;
        end
    end

    assign h_gnt    = h_gnt_s;
    assign h_rvalid = h_rvalid_r;
    assign h_rdata  = h_rdata_r;
    assign cpu_rst  = cpu_rst_r;
    assign running  = running_r;
    assign cpu_idin = imem_dout;
    assign cpu_ddin = dmem_dout;

endmodule
